pip2_align_add: RTL

PIP2_ALIGN_ADD -- requirements
Module: pip2_align_add

---
 rtl/pe16_pkg.sv | 16 +
 rtl/align_shift.sv | 37 +++
 rtl/pip2_align_add.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pe16_pkg.sv
// Shared widths, defaults and constants for the 16-lane align/add pipeline.
package pe16_pkg;

  localparam int LANES         = 16;
  localparam int MAN_W         = 26;
  localparam int EXP_W         = 10;
  localparam int SHIFT_W       = 10;
  localparam int SUM_W         = 36;
  localparam int FP64_EXP_W    = 12;
  localparam int FP64_MAN_W    = 53;
  localparam int GUARD_DEF     = 6;
  localparam int SHIFT_SAT_DEF = 31;

  localparam logic [1:0] MODE_IDLE = 2'b11;

endpackage

// File: rtl/align_shift.sv
// One lane: append guard zeros, clamp the shift, arithmetic right shift, collect sticky.
module align_shift
  import pe16_pkg::*;
#(
  parameter int GUARD     = GUARD_DEF,
  parameter int SHIFT_SAT = SHIFT_SAT_DEF,
  localparam int AW       = MAN_W + GUARD
) (
  input  logic [MAN_W-1:0]   man,
  input  logic [SHIFT_W-1:0] shift,
  output logic [AW-1:0]      aligned,
  output logic               sticky
);

  logic [AW-1:0]      ext;
  logic [AW-1:0]      mask;
  logic [SHIFT_W-1:0] sh_clamp;

  assign ext = {man, {GUARD{1'b0}}};

  // The out-of-range test uses the raw amount so a huge shift reports every original bit as lost.
  always_comb begin
    sh_clamp = (shift >= SHIFT_W'(SHIFT_SAT)) ? SHIFT_W'(SHIFT_SAT) : shift;
    mask     = '0;
    aligned  = '0;
    sticky   = 1'b0;
    if (shift >= SHIFT_W'(AW)) begin
      aligned = {AW{ext[AW-1]}};
      sticky  = |ext;
    end else begin
      aligned = $signed(ext) >>> sh_clamp;
      mask    = ~({AW{1'b1}} << sh_clamp);
      sticky  = |(ext & mask);
    end
  end

endmodule

// File: rtl/pip2_align_add.sv
// Two-stage pipeline: align 16 signed lane products, reduce to 4 partial sums, then to one sum.
module pip2_align_add
  import pe16_pkg::*;
#(
  parameter int GUARD     = GUARD_DEF,
  parameter int SHIFT_SAT = SHIFT_SAT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            mode_sel_pip1,
  input  logic                  i_valid,
  input  logic [EXP_W-1:0]      i_exp_max,
  input  logic [SHIFT_W-1:0]    i_shift0, i_shift1, i_shift2, i_shift3,
  input  logic [SHIFT_W-1:0]    i_shift4, i_shift5, i_shift6, i_shift7,
  input  logic [SHIFT_W-1:0]    i_shift8, i_shift9, i_shiftA, i_shiftB,
  input  logic [SHIFT_W-1:0]    i_shiftC, i_shiftD, i_shiftE, i_shiftF,
  input  logic [MAN_W-1:0]      i_man_AB0, i_man_AB1, i_man_AB2, i_man_AB3,
  input  logic [MAN_W-1:0]      i_man_AB4, i_man_AB5, i_man_AB6, i_man_AB7,
  input  logic [MAN_W-1:0]      i_man_AB8, i_man_AB9, i_man_ABA, i_man_ABB,
  input  logic [MAN_W-1:0]      i_man_ABC, i_man_ABD, i_man_ABE, i_man_ABF,
  input  logic                  i_sign_AB_fp64,
  input  logic [FP64_EXP_W-1:0] i_exp_AB_fp64,
  input  logic [FP64_MAN_W-1:0] i_man_A_53b,
  input  logic [FP64_MAN_W-1:0] i_man_B_53b,
  output logic [1:0]            mode_sel_pip2,
  output logic                  o_valid,
  output logic [EXP_W-1:0]      o_exp_max,
  output logic [SUM_W-1:0]      o_sum,
  output logic                  o_sticky,
  output logic                  o_sign_AB_fp64,
  output logic [FP64_EXP_W-1:0] o_exp_AB_fp64,
  output logic [FP64_MAN_W-1:0] o_man_A_53b,
  output logic [FP64_MAN_W-1:0] o_man_B_53b
);

  localparam int AW = MAN_W + GUARD;

  logic [MAN_W-1:0]   man     [LANES];
  logic [SHIFT_W-1:0] shift   [LANES];
  logic [AW-1:0]      aligned [LANES];
  logic [LANES-1:0]   sticky_lane;

  assign man[0]  = i_man_AB0;  assign man[1]  = i_man_AB1;
  assign man[2]  = i_man_AB2;  assign man[3]  = i_man_AB3;
  assign man[4]  = i_man_AB4;  assign man[5]  = i_man_AB5;
  assign man[6]  = i_man_AB6;  assign man[7]  = i_man_AB7;
  assign man[8]  = i_man_AB8;  assign man[9]  = i_man_AB9;
  assign man[10] = i_man_ABA;  assign man[11] = i_man_ABB;
  assign man[12] = i_man_ABC;  assign man[13] = i_man_ABD;
  assign man[14] = i_man_ABE;  assign man[15] = i_man_ABF;

  assign shift[0]  = i_shift0;  assign shift[1]  = i_shift1;
  assign shift[2]  = i_shift2;  assign shift[3]  = i_shift3;
  assign shift[4]  = i_shift4;  assign shift[5]  = i_shift5;
  assign shift[6]  = i_shift6;  assign shift[7]  = i_shift7;
  assign shift[8]  = i_shift8;  assign shift[9]  = i_shift9;
  assign shift[10] = i_shiftA;  assign shift[11] = i_shiftB;
  assign shift[12] = i_shiftC;  assign shift[13] = i_shiftD;
  assign shift[14] = i_shiftE;  assign shift[15] = i_shiftF;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    align_shift #(.GUARD(GUARD), .SHIFT_SAT(SHIFT_SAT)) u_align (
      .man     (man[l]),
      .shift   (shift[l]),
      .aligned (aligned[l]),
      .sticky  (sticky_lane[l])
    );
  end

  logic [SUM_W-1:0]      part_nxt [4];
  logic [SUM_W-1:0]      part_p1  [4];
  logic [SUM_W-1:0]      sum_nxt;
  logic                  valid_p1;
  logic [1:0]            mode_p1;
  logic                  sticky_p1;
  logic [EXP_W-1:0]      exp_p1;
  logic                  sign_p1;
  logic [FP64_EXP_W-1:0] exp_ab_p1;
  logic [FP64_MAN_W-1:0] man_a_p1;
  logic [FP64_MAN_W-1:0] man_b_p1;

  // Lanes are sign-extended to the full sum width, so neither tree level can overflow.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      part_nxt[g] = '0;
      for (int k = 0; k < 4; k++) begin
        part_nxt[g] = part_nxt[g] +
                      {{(SUM_W-AW){aligned[g*4+k][AW-1]}}, aligned[g*4+k]};
      end
    end
    sum_nxt = part_p1[0] + part_p1[1] + part_p1[2] + part_p1[3];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_p1      <= 1'b0;
      mode_p1       <= MODE_IDLE;
      o_valid       <= 1'b0;
      mode_sel_pip2 <= MODE_IDLE;
    end else begin
      valid_p1      <= i_valid;
      mode_p1       <= mode_sel_pip1;
      o_valid       <= valid_p1;
      mode_sel_pip2 <= mode_p1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int g = 0; g < 4; g++) part_p1[g] <= '0;
      sticky_p1 <= 1'b0;
      exp_p1    <= '0;
      sign_p1   <= 1'b0;
      exp_ab_p1 <= '0;
      man_a_p1  <= '0;
      man_b_p1  <= '0;
    end else if (i_valid) begin
      for (int g = 0; g < 4; g++) part_p1[g] <= part_nxt[g];
      sticky_p1 <= |sticky_lane;
      exp_p1    <= i_exp_max;
      sign_p1   <= i_sign_AB_fp64;
      exp_ab_p1 <= i_exp_AB_fp64;
      man_a_p1  <= i_man_A_53b;
      man_b_p1  <= i_man_B_53b;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_sum          <= '0;
      o_sticky       <= 1'b0;
      o_exp_max      <= '0;
      o_sign_AB_fp64 <= 1'b0;
      o_exp_AB_fp64  <= '0;
      o_man_A_53b    <= '0;
      o_man_B_53b    <= '0;
    end else if (valid_p1) begin
      o_sum          <= sum_nxt;
      o_sticky       <= sticky_p1;
      o_exp_max      <= exp_p1;
      o_sign_AB_fp64 <= sign_p1;
      o_exp_AB_fp64  <= exp_ab_p1;
      o_man_A_53b    <= man_a_p1;
      o_man_B_53b    <= man_b_p1;
    end
  end

endmodule
